thread_down_counter_scheduler: RTL
==================================

Name: thread_down_counter_scheduler

Overview:
Time-multiplexes one decrement-to-zero datapath across THREAD_COUNT hardware threads. Each thread has its own stored count and zero flag. A round-robin pointer visits one thread slot per cycle, in step with the barrel-thread rotation. Used for per-thread loop and timeout counters, so THREAD_COUNT independent counters cost one subtractor plus a register array.

Parameters:
WORD_WIDTH, 16, width of each thread's count.
THREAD_COUNT, 8, number of thread slots; must be >= 2.
THREAD_COUNT_WIDTH, 3, width of thread indices; must satisfy 2**THREAD_COUNT_WIDTH >= THREAD_COUNT.

Ports:
clock  input  1  system clock; all state updates on rising edge.
clear  input  1  synchronous, active-high reset.
run  input  THREAD_COUNT  per-thread count enable; only bit [current_thread] is used in a given cycle.
load_wren  input  1  write load_value into slot load_thread.
load_thread  input  THREAD_COUNT_WIDTH  target slot of a load; values >= THREAD_COUNT are ignored, with no write.
load_value  input  WORD_WIDTH  new count for the target slot.
current_thread  output  THREAD_COUNT_WIDTH  slot serviced this cycle (registered pointer).
current_count  output  WORD_WIDTH  stored count of current_thread (combinational read of the register array).
zero  output  THREAD_COUNT  registered per-thread zero flags.
expired  output  1  registered one-cycle pulse: a slot decremented from 1 to 0.
expired_thread  output  THREAD_COUNT_WIDTH  slot that expired; valid only when expired=1, otherwise holds its last value.

Behaviour:
- Reset: clear=1 at a rising edge forces the following, and overrides load_wren and run in that cycle.
  - current_thread=0
  - all counts=0
  - zero = all ones (every counter halted; a load is required to restart)
  - expired=0, expired_thread=0
- Pointer: current_thread increments by 1 every cycle when clear=0, wrapping from THREAD_COUNT-1 to 0. It never stalls.
- Servicing slot c=current_thread each cycle:
  - A load targeting c (load_wren=1, load_thread==c): count[c]<=load_value and zero[c]<=(load_value==0). The load overrides run. expired stays 0, even when load_value=0.
  - Otherwise, if run[c]=1 and zero[c]=0: count[c]<=count[c]-1 and zero[c]<=(count[c]==1).
    - If count[c]==1: expired<=1 and expired_thread<=c on the same edge.
  - Otherwise: count[c] and zero[c] hold.
- Loads to a non-current slot: load_wren=1 with load_thread!=c and load_thread<THREAD_COUNT writes that slot on the same edge.
  - count[load_thread]<=load_value, zero[load_thread]<=(load_value==0).
  - Servicing of slot c proceeds independently in the same cycle.
- expired is 0 in every cycle where the rule above does not set it. It is never high two cycles running unless consecutive slots both expire.
- Halt: a slot whose zero flag is 1 never decrements. The count never wraps below 0.
- Latency: a load or decrement of slot t is visible on zero[t] and count[t] one cycle after the servicing edge.
  - Between two visits, a slot is serviced exactly once per THREAD_COUNT cycles.
- Arithmetic: unsigned, WORD_WIDTH bits. Loading 0 marks the slot zero at once.
- A load whose load_value has the top bit set is treated as a large unsigned count, not as a negative number.
- Clear asserted mid-countdown discards all counts. The pointer restarts at slot 0 on the next cycle.

Test Plan:
1. Reset release:
   - Stimulus: clear for 2 cycles, then idle 16 cycles with run=all ones.
   - Required: zero=8'hFF throughout, expired never asserts, current_thread sequence 0,1,...,7,0,...
2. Countdown with expiry:
   - Stimulus: load slot 3 with value 3 (while it is not current); then run[3]=1.
   - Required: slot 3 decrements once per 8 cycles, 3→2→1→0. On the 1→0 visit, expired=1 with expired_thread=3 for exactly one cycle and zero[3]=1. Afterwards the count stays 0 and no further pulses occur.
3. Load/run collision:
   - Stimulus: slot 5 holds 10 and run[5]=1; on the cycle current_thread=5, load slot 5 with value 4.
   - Required: count becomes 4 (not 9) and expired=0.
4. Zero load:
   - Stimulus: load slot 0 with value 0 while it is counting.
   - Required: zero[0]=1 next cycle, expired stays 0, and run[0]=1 causes no underflow (count stays 0, not 16'hFFFF).
5. Independent loads:
   - Stimulus: with current_thread=2 decrementing 1→0, load slot 6 with value 7 in the same cycle.
   - Required: expired pulses with thread 2, count[6]=7, zero[6]=0.
   - Also: load_thread=7 with THREAD_COUNT=6 changes no state.
6. Clear mid-operation:
   - Stimulus: with slots 1 and 4 counting, assert clear for 1 cycle.
   - Required: all counts 0, zero all ones, current_thread=0 next cycle, expired=0.

Source files
------------

// File: rtl/thread_down_counter_scheduler.sv
// Barrel-threaded down-counter: one decrementer shared round-robin across THREAD_COUNT slots.
// Each slot keeps its own count and zero flag; loads may target any slot on any cycle.
module thread_down_counter_scheduler #(
    parameter int WORD_WIDTH         = 16,
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3
) (
    input  logic                          clock_i,
    input  logic                          clear_i,
    input  logic [THREAD_COUNT-1:0]       run_i,
    input  logic                          load_wren_i,
    input  logic [THREAD_COUNT_WIDTH-1:0] load_thread_i,
    input  logic [WORD_WIDTH-1:0]         load_value_i,
    output logic [THREAD_COUNT_WIDTH-1:0] current_thread_o,
    output logic [WORD_WIDTH-1:0]         current_count_o,
    output logic [THREAD_COUNT-1:0]       zero_o,
    output logic                          expired_o,
    output logic [THREAD_COUNT_WIDTH-1:0] expired_thread_o
);

    localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
    localparam logic [THREAD_COUNT_WIDTH:0]   NUM_THREADS = (THREAD_COUNT_WIDTH + 1)'(THREAD_COUNT);
    localparam logic [WORD_WIDTH-1:0]         ONE         = WORD_WIDTH'(1);

    logic [WORD_WIDTH-1:0]         count_q [THREAD_COUNT];
    logic [WORD_WIDTH-1:0]         count_d [THREAD_COUNT];
    logic [THREAD_COUNT-1:0]       zero_q, zero_d;
    logic [THREAD_COUNT_WIDTH-1:0] ptr_q, ptr_d;
    logic                          expired_q, expired_d;
    logic [THREAD_COUNT_WIDTH-1:0] expired_thread_q, expired_thread_d;

    logic                  load_valid;
    logic                  load_hits_current;
    logic [WORD_WIDTH-1:0] cur_count;

    assign load_valid        = load_wren_i && ({1'b0, load_thread_i} < NUM_THREADS);
    assign load_hits_current = load_valid && (load_thread_i == ptr_q);
    assign cur_count         = count_q[ptr_q];

    always_comb begin
        count_d          = count_q;
        zero_d           = zero_q;
        expired_d        = 1'b0;
        expired_thread_d = expired_thread_q;
        ptr_d            = (ptr_q == LAST_THREAD) ? '0 : ptr_q + 1'b1;

        // A load to the serviced slot wins over its decrement and never signals expiry.
        if (!load_hits_current && run_i[ptr_q] && !zero_q[ptr_q]) begin
            count_d[ptr_q] = cur_count - ONE;
            zero_d[ptr_q]  = (cur_count == ONE);
            if (cur_count == ONE) begin
                expired_d        = 1'b1;
                expired_thread_d = ptr_q;
            end
        end

        if (load_valid) begin
            count_d[load_thread_i] = load_value_i;
            zero_d[load_thread_i]  = (load_value_i == '0);
        end
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            for (int i = 0; i < THREAD_COUNT; i++) begin
                count_q[i] <= '0;
            end
            zero_q           <= '1;
            ptr_q            <= '0;
            expired_q        <= 1'b0;
            expired_thread_q <= '0;
        end else begin
            count_q          <= count_d;
            zero_q           <= zero_d;
            ptr_q            <= ptr_d;
            expired_q        <= expired_d;
            expired_thread_q <= expired_thread_d;
        end
    end

    assign current_thread_o = ptr_q;
    assign current_count_o  = cur_count;
    assign zero_o           = zero_q;
    assign expired_o        = expired_q;
    assign expired_thread_o = expired_thread_q;

endmodule
